// File: rtl/alu_fun_decoder.sv
// alu_fun_decoder: decodes opcode/funct into ALUFun/Sign/illegal behind a 2-entry FIFO
module alu_fun_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] ALUFun,
  output logic       Sign,
  output logic       illegal
);
  logic [7:0] mem [2];
  logic [7:0] dec;
  logic [1:0] count;
  logic       wp, rp, push, pop;
  // entries are packed as {illegal, Sign, ALUFun}
  always_comb begin
    dec = {2'b10, 6'b000000};
    case (opcode)
      6'h00:
        case (funct)
          6'h20: dec = {2'b01, 6'b000000};
          6'h21: dec = {2'b00, 6'b000000};
          6'h22: dec = {2'b01, 6'b000001};
          6'h23: dec = {2'b00, 6'b000001};
          6'h24: dec = {2'b00, 6'b011000};
          6'h25: dec = {2'b00, 6'b011110};
          6'h26: dec = {2'b00, 6'b010110};
          6'h27: dec = {2'b00, 6'b010001};
          6'h00: dec = {2'b00, 6'b100000};
          6'h02: dec = {2'b00, 6'b100001};
          6'h03: dec = {2'b00, 6'b100011};
          6'h2A: dec = {2'b01, 6'b110101};
          6'h2B: dec = {2'b00, 6'b110101};
          6'h08: dec = {2'b00, 6'b000000};
          default: dec = {2'b10, 6'b000000};
        endcase
      6'h08: dec = {2'b01, 6'b000000};
      6'h09: dec = {2'b00, 6'b000000};
      6'h0C: dec = {2'b00, 6'b011000};
      6'h0F: dec = {2'b00, 6'b011010};
      6'h0A: dec = {2'b01, 6'b110101};
      6'h0B: dec = {2'b00, 6'b110101};
      6'h23: dec = {2'b01, 6'b000000};
      6'h2B: dec = {2'b01, 6'b000000};
      6'h04: dec = {2'b01, 6'b110011};
      6'h05: dec = {2'b01, 6'b110001};
      6'h06: dec = {2'b01, 6'b111101};
      6'h07: dec = {2'b01, 6'b111111};
      6'h01: dec = {2'b01, 6'b111011};
      6'h02: dec = {2'b00, 6'b000000};
      6'h03: dec = {2'b00, 6'b000000};
      default: dec = {2'b10, 6'b000000};
    endcase
  end
  assign in_ready  = (count != 2'd2) || out_ready;
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {illegal, Sign, ALUFun} = out_valid ? mem[rp] : 8'h00;
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= dec;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_alu_fun_decoder.sv
// tb_alu_fun_decoder: scoreboard bench for the decoder FIFO, expected entries queued on input handshake
module tb_alu_fun_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] ALUFun;
  logic       Sign;
  logic       illegal;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] q [$];
  // table rows are {code, Sign, ALUFun}
  logic [12:0] rtab [14] = '{
    {6'h20, 1'b1, 6'b000000}, {6'h21, 1'b0, 6'b000000}, {6'h22, 1'b1, 6'b000001},
    {6'h23, 1'b0, 6'b000001}, {6'h24, 1'b0, 6'b011000}, {6'h25, 1'b0, 6'b011110},
    {6'h26, 1'b0, 6'b010110}, {6'h27, 1'b0, 6'b010001}, {6'h00, 1'b0, 6'b100000},
    {6'h02, 1'b0, 6'b100001}, {6'h03, 1'b0, 6'b100011}, {6'h2A, 1'b1, 6'b110101},
    {6'h2B, 1'b0, 6'b110101}, {6'h08, 1'b0, 6'b000000}};
  logic [12:0] otab [16] = '{
    {6'h08, 1'b1, 6'b000000}, {6'h09, 1'b0, 6'b000000}, {6'h0C, 1'b0, 6'b011000},
    {6'h0F, 1'b0, 6'b011010}, {6'h0A, 1'b1, 6'b110101}, {6'h0B, 1'b0, 6'b110101},
    {6'h23, 1'b1, 6'b000000}, {6'h2B, 1'b1, 6'b000000}, {6'h04, 1'b1, 6'b110011},
    {6'h05, 1'b1, 6'b110001}, {6'h06, 1'b1, 6'b111101}, {6'h07, 1'b1, 6'b111111},
    {6'h01, 1'b1, 6'b111011}, {6'h02, 1'b0, 6'b000000}, {6'h03, 1'b0, 6'b000000},
    {6'h00, 1'b0, 6'b000000}};

  alu_fun_decoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
    .ALUFun(ALUFun), .Sign(Sign), .illegal(illegal));

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_dec(input logic [5:0] op, input logic [5:0] fn);
    logic [7:0] r = 8'h80;
    if (op == 6'h00) begin
      foreach (rtab[i]) if (rtab[i][12:7] == fn) r = {1'b0, rtab[i][6:0]};
    end else begin
      for (int i = 0; i < 15; i++) if (otab[i][12:7] == op) r = {1'b0, otab[i][6:0]};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one cycle: drive at negedge, check before the edge, update the model after it
  task automatic step(input logic iv, input logic [5:0] op, input logic [5:0] fn,
                      input logic ordy, input logic rst_n);
    logic hs_in, hs_out;
    in_valid = iv; opcode = op; funct = fn; out_ready = ordy; reset = rst_n;
    #1;
    chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
    chk("in_ready", {7'd0, in_ready}, {7'd0, (q.size() < 2) || ordy});
    chk(q.size() != 0 ? "head" : "empty", {illegal, Sign, ALUFun}, q.size() != 0 ? q[0] : 8'h00);
    hs_out = (q.size() != 0) && ordy;
    hs_in  = iv && ((q.size() < 2) || ordy);
    @(posedge clk);
    if (!rst_n) q.delete();
    else begin
      if (hs_out) void'(q.pop_front());
      if (hs_in) q.push_back(ref_dec(op, fn));
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(0, 6'h00, 6'h00, 0, 1);
    step(1, 6'h00, 6'h27, 1, 1);
    step(0, 6'h00, 6'h00, 1, 1);
    step(0, 6'h00, 6'h00, 1, 1);
    step(1, 6'h04, 6'h00, 0, 1);
    step(1, 6'h0B, 6'h00, 0, 1);
    step(1, 6'h09, 6'h00, 0, 1);
    step(0, 6'h00, 6'h00, 0, 1);
    repeat (3) step(0, 6'h00, 6'h00, 1, 1);
    step(1, 6'h04, 6'h00, 0, 1);
    step(1, 6'h0B, 6'h00, 0, 1);
    step(1, 6'h08, 6'h00, 1, 1);
    repeat (4) step(0, 6'h00, 6'h00, 1, 1);
    step(1, 6'h00, 6'h3F, 0, 1);
    step(1, 6'h3F, 6'h00, 0, 1);
    step(0, 6'h00, 6'h00, 0, 1);
    step(1, 6'h00, 6'h25, 1, 1);
    repeat (4) step(0, 6'h00, 6'h00, 1, 1);
    step(1, 6'h04, 6'h00, 0, 1);
    step(1, 6'h05, 6'h00, 0, 1);
    step(1, 6'h06, 6'h00, 0, 0);
    step(0, 6'h00, 6'h00, 0, 1);
    step(1, 6'h07, 6'h00, 1, 1);
    step(0, 6'h00, 6'h00, 1, 1);
    for (int op = 0; op < 64; op++)
      for (int fn = 0; fn < 64; fn++)
        step(1, 6'(op), 6'(fn), 1, 1);
    repeat (3) step(0, 6'h00, 6'h00, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_fun_decoder.md
ALU_FUN_DECODER -- requirements
Module: alu_fun_decoder

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-003 The module SHALL have port in_valid, input, 1 bit: the instruction fields are presented this cycle.
REQ-004 The module SHALL have port in_ready, output, 1 bit: the decoder accepts the fields this cycle.
REQ-005 The module SHALL have port opcode, input, 6 bits: instruction bits [31:26].
REQ-006 The module SHALL have port funct, input, 6 bits: instruction bits [5:0].
REQ-007 The module SHALL have port out_valid, output, 1 bit: the head entry holds a decoded result.
REQ-008 The module SHALL have port out_ready, input, 1 bit: the ALU side consumes the head entry this cycle.
REQ-009 The module SHALL have port ALUFun, output, 6 bits: the decoded ALU function code.
REQ-010 The module SHALL have port Sign, output, 1 bit: 1 selects signed arithmetic or compare.
REQ-011 The module SHALL have port illegal, output, 1 bit: the opcode/funct pair is unsupported.

Function
REQ-012 Input handshake: a transfer SHALL occur exactly when in_valid && in_ready; output transfer exactly when out_valid && out_ready.
REQ-013 Decoded entries SHALL be stored in a 2-entry FIFO with a 2-bit count (0..2), a write pointer and a read pointer, each pointer 1 bit and wrapping 1->0.
REQ-014 in_ready SHALL equal (count<2) || out_ready: a full FIFO still accepts input in the same cycle its head is popped.
REQ-015 out_valid SHALL equal (count!=0); there SHALL be no combinational path from in_valid to out_valid (minimum latency 1 cycle).
REQ-016 ALUFun, Sign and illegal SHALL come from the head entry and SHALL stay stable while out_valid && !out_ready.
REQ-017 Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged, with both pointers advancing.
REQ-018 When count==0, ALUFun, Sign and illegal SHALL read 6'b000000, 0 and 0.
REQ-019 R-type (opcode 0x00) SHALL decode funct as ALUFun/Sign:
- add 0x20 -> 000000/1; addu 0x21 -> 000000/0; sub 0x22 -> 000001/1; subu 0x23 -> 000001/0
- and 0x24 -> 011000/0; or 0x25 -> 011110/0; xor 0x26 -> 010110/0; nor 0x27 -> 010001/0
- sll 0x00 -> 100000/0; srl 0x02 -> 100001/0; sra 0x03 -> 100011/0
- slt 0x2A -> 110101/1; sltu 0x2B -> 110101/0; jr 0x08 -> 000000/0
REQ-020 Other opcodes SHALL decode as ALUFun/Sign (funct ignored):
- addi 0x08 -> 000000/1; addiu 0x09 -> 000000/0; andi 0x0C -> 011000/0; lui 0x0F -> 011010/0
- slti 0x0A -> 110101/1; sltiu 0x0B -> 110101/0; lw 0x23, sw 0x2B -> 000000/1
- beq 0x04 -> 110011/1; bne 0x05 -> 110001/1; blez 0x06 -> 111101/1; bgtz 0x07 -> 111111/1; bltz 0x01 -> 111011/1
- j 0x02, jal 0x03 -> 000000/0
REQ-021 Any unlisted opcode, or R-type with an unlisted funct, SHALL be enqueued with ALUFun 000000, Sign 0, illegal 1; illegal SHALL be 0 for every listed pair.
REQ-022 Illegal entries SHALL occupy the FIFO and be handshaken exactly like legal ones; they SHALL never be dropped.
REQ-023 Fields presented without in_valid, or while in_ready=0, SHALL not change any state.

Reset
REQ-024 reset=0 at a rising clk edge SHALL set count=0 and both pointers=0, giving out_valid=0, in_ready=1, ALUFun=000000, Sign=0, illegal=0.
REQ-025 Reset SHALL override a simultaneous push or pop; entries in flight SHALL be discarded, including on reset mid-stream.
REQ-026 Stored entry data need not be cleared by reset.

Verification
REQ-027 Single op: push opcode 0x00 funct 0x27 with out_ready=1 -> next cycle out_valid=1, ALUFun=010001, Sign=0, illegal=0; the following cycle out_valid=0.
REQ-028 Backpressure: out_ready=0, push beq (0x04) then sltiu (0x0B) -> count=2, in_ready=0, head ALUFun=110011 Sign=1 held; raise out_ready -> 110101/0 next, then empty.
REQ-029 Full pass-through: count=2, out_ready=1, push addi (0x08) -> in_ready=1, count stays 2; outputs in order beq, sltiu, addi (000000/1).
REQ-030 Illegal: push opcode 0x00 funct 0x3F, then opcode 0x3F -> two entries with illegal=1, ALUFun=000000; a subsequent or (0x25) gives illegal=0, ALUFun=011110.
REQ-031 Reset mid-stream: count=2, drive reset=0 for one edge with in_valid=1 -> out_valid=0, in_ready=1, count=0; the pushed fields are not stored.
REQ-032 Exhaustive: sweep all 64 opcodes x 64 functs with out_ready=1 -> every output matches REQ-019..REQ-021.
